pipe_stage_reg: RTL and testbench

Parametrised, flow-controlled pipeline stage register for the pipelined RISC-V core. It replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block carrying an opaque data payload plus a control bundle. It adds a valid/ready handshake, stall, flush and guaranteed bubble zeroing of control bits. An optional skid entry lets the hazard unit register its stall decision.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_stage_reg_if.sv | 15 +
 rtl/pipe_stage_slot.sv | 56 +++++
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 tb/tb_pipe_stage_reg.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control bundle layout, per-stage payload widths
// and the slot occupancy encoding used by pipe_stage_reg.
package pipe_pkg;

    localparam int unsigned CTRL_W = 9;

    // Bit positions inside the control bundle
    localparam int unsigned CTRL_BRANCH    = 0;
    localparam int unsigned CTRL_MEMREAD   = 1;
    localparam int unsigned CTRL_MEMTOREG  = 2;
    localparam int unsigned CTRL_MEMWRITE  = 3;
    localparam int unsigned CTRL_REGWRITE  = 4;
    localparam int unsigned CTRL_ALUSRC    = 5;
    localparam int unsigned CTRL_ALUOP_LSB = 6;
    localparam int unsigned CTRL_SPARE     = 8;

    localparam int unsigned DEF_DATA_W = 64;

    // Payload widths: IF/ID pc+instr; ID/EX pc+rs1+rs2+imm+3 regidx+funct3;
    // EX/MEM target+alu+rs2+rd+zero; MEM/WB rdata+alu+rd
    localparam int unsigned IFID_W  = 64;
    localparam int unsigned IDEX_W  = 146;
    localparam int unsigned EXMEM_W = 102;
    localparam int unsigned MEMWB_W = 69;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat channel between pipeline stages: payload plus control bundle.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 9
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, data, ctrl, input ready);
    modport slave  (input valid, data, ctrl, output ready);

endinterface

// File: rtl/pipe_stage_slot.sv
// One beat of storage: valid state plus data/ctrl registers with load and clear.
// Clear wins over load; ctrl returns to CTRL_RST whenever the slot empties.
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter int unsigned       CTRL_W   = pipe_pkg::CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            ctrl_q  <= CTRL_RST;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Data is kept on clear so the output holds its last value while empty
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear_i) begin
            state_d = SLOT_EMPTY;
            ctrl_d  = CTRL_RST;
        end else if (load_i) begin
            state_d = SLOT_FULL;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic flow-controlled pipeline stage register with flush and bubble zeroing.
// Define PIPE_STAGE_SKID_EN for a second (skid) entry and a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter int unsigned       CTRL_W   = pipe_pkg::CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    pipe_stage_reg_if.slave         in_i,
    pipe_stage_reg_if.master        out_o,
    output logic [1:0]              occupancy
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              m_load;
    logic              m_clear;
    logic [DATA_W-1:0] m_data_in;
    logic [CTRL_W-1:0] m_ctrl_in;
    logic              accept;
    logic              consume;

    assign accept  = in_i.valid && in_i.ready;
    assign consume = m_valid && out_o.ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic              s_load;
    logic              s_clear;

    // Ready comes straight from the skid flop, breaking the out_ready path
    assign in_i.ready = !s_valid;

    always_comb begin
        m_load    = 1'b0;
        m_clear   = flush;
        m_data_in = in_i.data;
        m_ctrl_in = in_i.ctrl;
        s_load    = 1'b0;
        s_clear   = flush;
        if (!flush) begin
            if (!m_valid) begin
                m_load = accept;
            end else if (consume) begin
                if (s_valid) begin
                    m_load    = 1'b1;
                    m_data_in = s_data;
                    m_ctrl_in = s_ctrl;
                    s_clear   = 1'b1;
                end else if (accept) begin
                    m_load = 1'b1;
                end else begin
                    m_clear = 1'b1;
                end
            end else begin
                s_load = accept;
            end
        end
    end

    pipe_stage_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (CTRL_RST)
    ) u_slot_s (
        .clk     (clk),
        .reset   (reset),
        .load_i  (s_load),
        .clear_i (s_clear),
        .data_i  (in_i.data),
        .ctrl_i  (in_i.ctrl),
        .valid_o (s_valid),
        .data_o  (s_data),
        .ctrl_o  (s_ctrl)
    );

    assign occupancy = 2'(m_valid) + 2'(s_valid);
`else
    // Single entry: accept whenever the held beat leaves this edge or none is held
    assign in_i.ready = out_o.ready || !m_valid;

    always_comb begin
        m_data_in = in_i.data;
        m_ctrl_in = in_i.ctrl;
        m_load    = accept && !flush;
        m_clear   = flush || (consume && !accept);
    end

    assign occupancy = {1'b0, m_valid};
`endif

    pipe_stage_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (CTRL_RST)
    ) u_slot_m (
        .clk     (clk),
        .reset   (reset),
        .load_i  (m_load),
        .clear_i (m_clear),
        .data_i  (m_data_in),
        .ctrl_i  (m_ctrl_in),
        .valid_o (m_valid),
        .data_o  (m_data),
        .ctrl_o  (m_ctrl)
    );

    assign out_o.valid = m_valid;
    assign out_o.data  = m_data;
    assign out_o.ctrl  = m_ctrl;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a beat scoreboard; honours PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) in_if ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) out_if ();

    pipe_stage_reg #(
        .DATA_W   (DW),
        .CTRL_W   (CW),
        .CTRL_RST ('0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_i      (in_if),
        .out_o     (out_if),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    bit saw77    = 1'b0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    beat_t       sb_q[$];
    int unsigned mdl_cnt;
    logic        exp_rdy;
    logic        acc;
    logic        cons;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare the held beat, then advance the model for the coming edge
    always @(negedge clk) begin
        mdl_cnt = sb_q.size();
`ifdef PIPE_STAGE_SKID_EN
        exp_rdy = (mdl_cnt < 2);
`else
        exp_rdy = out_if.ready || (mdl_cnt == 0);
`endif
        check("in_ready", 64'(in_if.ready), 64'(exp_rdy));
        check("out_valid", 64'(out_if.valid), 64'(mdl_cnt != 0));
        check("occupancy", 64'(occupancy), 64'(mdl_cnt));
        if (mdl_cnt != 0) begin
            check("out_data", out_if.data, sb_q[0].d);
            check("out_ctrl", 64'(out_if.ctrl), 64'(sb_q[0].c));
        end else begin
            check("bubble_ctrl", 64'(out_if.ctrl), 64'(0));
        end
        if (out_if.valid && out_if.data == 64'h77) saw77 = 1'b1;
        acc  = in_if.valid && exp_rdy;
        cons = (mdl_cnt != 0) && out_if.ready;
        if (reset) begin
            sb_q.delete();
        end else begin
            if (cons) begin
                void'(sb_q.pop_front());
                n_out++;
            end
            if (flush) sb_q.delete();
            else if (acc) sb_q.push_back(beat_t'{d: in_if.data, c: in_if.ctrl});
        end
    end

    initial begin
        int base;

        // Reset sweep with a live upstream beat
        reset        = 1'b1;
        flush        = 1'b0;
        in_if.valid  = 1'b1;
        in_if.data   = 64'hDEAD;
        in_if.ctrl   = 9'h1FF;
        out_if.ready = 1'b1;
        step();
        check("rst_data", out_if.data, 64'h0);
        check("rst_valid", 64'(out_if.valid), 64'(0));
        check("rst_ctrl", 64'(out_if.ctrl), 64'(0));
        step();
        check("rst_occ", 64'(occupancy), 64'(0));
        reset       = 1'b0;
        in_if.valid = 1'b0;
        step();

        // Streaming: eight back-to-back beats
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            in_if.valid = 1'b1;
            in_if.data  = 64'(i);
            in_if.ctrl  = 9'(i);
            step();
            check("stream_valid", 64'(out_if.valid), 64'(1));
            check("stream_data", out_if.data, 64'(i));
        end
        in_if.valid = 1'b0;
        step();
        step();
        check("stream_count", 64'(n_out - base), 64'(8));

        // Regwrite isolation
        in_if.valid = 1'b1;
        in_if.data  = 64'h5;
        in_if.ctrl  = 9'(1 << CTRL_MEMWRITE);
        step();
        in_if.valid = 1'b0;
        check("rw_regwrite", 64'(out_if.ctrl[CTRL_REGWRITE]), 64'(0));
        check("rw_memwrite", 64'(out_if.ctrl[CTRL_MEMWRITE]), 64'(1));
        step();

        // Stall for three cycles holding A5, B6 offered behind it
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        in_if.data   = 64'hA5;
        in_if.ctrl   = 9'h012;
        step();
        in_if.data = 64'hB6;
        in_if.ctrl = 9'h024;
`ifdef PIPE_STAGE_SKID_EN
        check("stall_ready", 64'(in_if.ready), 64'(1));
`else
        check("stall_ready", 64'(in_if.ready), 64'(0));
`endif
        step();
`ifdef PIPE_STAGE_SKID_EN
        in_if.valid = 1'b0;
        check("skid_occ", 64'(occupancy), 64'(2));
        check("skid_ready", 64'(in_if.ready), 64'(0));
`endif
        check("stall_hold1", out_if.data, 64'hA5);
        step();
        check("stall_hold2", out_if.data, 64'hA5);
        step();
        check("stall_hold3", out_if.data, 64'hA5);
        out_if.ready = 1'b1;
        step();
        in_if.valid = 1'b0;
        check("release_next", out_if.data, 64'hB6);
        step();
        step();

        // Flush during accept into an empty stage
        in_if.valid = 1'b1;
        in_if.data  = 64'h77;
        in_if.ctrl  = 9'h1FF;
        flush       = 1'b1;
        step();
        flush       = 1'b0;
        in_if.valid = 1'b0;
        check("flush_valid", 64'(out_if.valid), 64'(0));
        check("flush_ctrl", 64'(out_if.ctrl), 64'(0));
        check("flush_occ", 64'(occupancy), 64'(0));

        // Flush while a stalled beat is held and another is offered
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        in_if.data   = 64'h11;
        in_if.ctrl   = 9'h010;
        step();
        in_if.data = 64'h77;
        flush      = 1'b1;
        step();
        flush       = 1'b0;
        in_if.valid = 1'b0;
        check("flush_full_valid", 64'(out_if.valid), 64'(0));
        check("flush_full_occ", 64'(occupancy), 64'(0));

        // Reset in the middle of a stall with the stage full
        in_if.valid = 1'b1;
        in_if.data  = 64'hC1;
        in_if.ctrl  = 9'h011;
        step();
        in_if.data = 64'hC2;
        step();
        in_if.valid = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        check("pre_rst_occ", 64'(occupancy), 64'(2));
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", 64'(out_if.valid), 64'(0));
        check("mid_rst_occ", 64'(occupancy), 64'(0));
        check("mid_rst_ready", 64'(in_if.ready), 64'(1));
        out_if.ready = 1'b1;
        step();
        step();

        check("never_77", 64'(saw77), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
